// File: rtl/irq_exc_ctrl.sv
// irq_exc_ctrl: sequential interrupt/exception controller.
// Synchronises N external interrupt lines, latches them as pending (edge or
// level), arbitrates lowest-index-first against the decoder's illegal
// instruction flag, and issues one-cycle trap pulses that steer PCSrc.
// EPC and cause are captured on each take; in_trap tracks kernel residency
// until eret.
module irq_exc_ctrl #(
    parameter int NUM_IRQ     = 4,
    parameter int PC_WIDTH    = 32,
    parameter int EDGE_MODE   = 1,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic                exc_in,
    input  logic [PC_WIDTH-1:0] pc_cur,
    input  logic                kernel,
    input  logic                stall,
    input  logic                eret,
    input  logic                mask_we,
    input  logic [NUM_IRQ-1:0]  mask_wdata,
    output logic [NUM_IRQ-1:0]  mask,
    output logic [NUM_IRQ-1:0]  pending,
    output logic                take_irq,
    output logic                take_exc,
    output logic [PC_WIDTH-1:0] epc,
    output logic [ID_W:0]       cause,
    output logic                in_trap
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_TRAP = 1'b1;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] irq_d;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] req;
    logic [NUM_IRQ-1:0] win_onehot;
    logic [NUM_IRQ-1:0] clr_vec;
    logic [ID_W-1:0]    winner;
    logic [0:0]         state_q;
    logic               can_take;

    // Multi-flop synchroniser bringing the asynchronous request lines into clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign irq_s = sync_q[SYNC_STAGES-1];

    // One-cycle delayed copy of the synchronised lines for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_d <= '0;
        end else begin
            irq_d <= irq_s;
        end
    end

    assign rise = irq_s & ~irq_d;

    generate
        if (EDGE_MODE != 0) begin : gen_edge
            // Edge-latched pending: a new edge wins over a same-cycle clear
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pending <= '0;
                end else begin
                    pending <= (pending & ~clr_vec) | rise;
                end
            end
        end else begin : gen_level
            assign pending = irq_s;
        end
    endgenerate

    // Software-visible enable mask; a write lands at the next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
        end else if (mask_we) begin
            mask <= mask_wdata;
        end
    end

    assign req = pending & mask;

    // Fixed priority arbiter: the lowest-numbered requesting line wins
    always_comb begin
        winner     = '0;
        win_onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner     = ID_W'(i);
                win_onehot = NUM_IRQ'(1) << i;
            end
        end
    end

    assign can_take = (state_q == ST_IDLE) & ~kernel & ~stall;
    assign take_irq = can_take & (|req);
    assign take_exc = can_take & exc_in & ~take_irq;
    assign clr_vec  = take_irq ? win_onehot : '0;
    assign in_trap  = (state_q == ST_TRAP);

    // Trap state plus EPC/cause capture; no nesting while a trap is active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            epc     <= '0;
            cause   <= '0;
        end else if (take_irq || take_exc) begin
            state_q <= ST_TRAP;
            epc     <= pc_cur;
            cause   <= take_irq ? {1'b1, winner} : '0;
        end else if ((state_q == ST_TRAP) && eret) begin
            state_q <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_irq_exc_ctrl.sv
// tb_irq_exc_ctrl: self-checking bench for irq_exc_ctrl (4 lines, edge mode,
// two synchroniser stages). A directed vector table and hand-written
// sequences cover the scenarios from the design notes; a randomised phase is
// compared against a cycle-level behavioural model of the trap rules.
module tb_irq_exc_ctrl;

    localparam int N    = 4;
    localparam int SYNC = 2;

    logic        clk;
    logic        rst_n;
    logic [3:0]  irq_in;
    logic        exc_in;
    logic [31:0] pc_cur;
    logic        kernel;
    logic        stall;
    logic        eret;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic [3:0]  mask;
    logic [3:0]  pending;
    logic        take_irq;
    logic        take_exc;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic        in_trap;

    int n_checks;
    int n_fail;

    // Behavioural model state for the randomised phase
    logic [3:0]  m_pend;
    logic [3:0]  m_mask;
    logic [31:0] m_epc;
    logic [4:0]  m_cause;
    logic        m_trap;
    logic [3:0]  hist [$];

    typedef struct {
        logic [3:0]  irq;
        logic        exc;
        logic        kern;
        logic        stl;
        logic        ert;
        logic        mwe;
        logic [3:0]  mwd;
        logic [31:0] pc;
        logic        e_ti;
        logic        e_te;
        logic [3:0]  e_pend;
        logic        e_trap;
        logic [4:0]  e_cause;
        logic [31:0] e_epc;
    } vec_t;

    vec_t vecs [11];

    irq_exc_ctrl #(
        .NUM_IRQ(N), .PC_WIDTH(32), .EDGE_MODE(1), .SYNC_STAGES(SYNC), .ID_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .exc_in(exc_in),
        .pc_cur(pc_cur), .kernel(kernel), .stall(stall), .eret(eret),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .mask(mask),
        .pending(pending), .take_irq(take_irq), .take_exc(take_exc),
        .epc(epc), .cause(cause), .in_trap(in_trap)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] i_irq, input logic i_exc,
                                 input logic i_kern, input logic i_stl,
                                 input logic i_ert, input logic i_mwe,
                                 input logic [3:0] i_mwd, input logic [31:0] i_pc);
        irq_in     = i_irq;
        exc_in     = i_exc;
        kernel     = i_kern;
        stall      = i_stl;
        eret       = i_ert;
        mask_we    = i_mwe;
        mask_wdata = i_mwd;
        pc_cur     = i_pc;
    endtask

    task automatic toEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic toDrive();
        @(negedge clk);
    endtask

    task automatic checkPre(input string tag, input logic ti, input logic te);
        #1;
        checkOutput({tag, "_take_irq"}, 64'(take_irq), 64'(ti));
        checkOutput({tag, "_take_exc"}, 64'(take_exc), 64'(te));
    endtask

    task automatic checkPost(input string tag, input logic [3:0] pend, input logic trap);
        checkOutput({tag, "_pending"}, 64'(pending), 64'(pend));
        checkOutput({tag, "_in_trap"}, 64'(in_trap), 64'(trap));
    endtask

    // One directed cycle: drive, check the combinational takes, clock, check state
    task automatic dirCycle(input string tag, input logic [3:0] i_irq, input logic i_exc,
                            input logic i_kern, input logic i_stl, input logic i_ert,
                            input logic ti, input logic te,
                            input logic [3:0] pend, input logic trap);
        applyStimulus(i_irq, i_exc, i_kern, i_stl, i_ert, 1'b0, 4'h0, pc_cur);
        checkPre(tag, ti, te);
        toEdge();
        checkPost(tag, pend, trap);
        toDrive();
    endtask

    function automatic int bitIndex(input logic [3:0] onehot);
        int n;
        logic [3:0] v;
        n = 0;
        v = onehot;
        while (v > 4'd1) begin
            v = v >> 1;
            n++;
        end
        return n;
    endfunction

    task automatic modelReset();
        m_pend  = '0;
        m_mask  = '0;
        m_epc   = '0;
        m_cause = '0;
        m_trap  = 1'b0;
        hist.delete();
        for (int i = 0; i < SYNC + 1; i++) hist.push_back(4'h0);
    endtask

    task automatic doReset();
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        toDrive();
        rst_n = 1'b1;
    endtask

    // One randomised cycle compared against the behavioural model
    task automatic randomCycle(inout logic [3:0] cur_irq);
        logic [3:0] req, low, rise, s, d;
        logic ti, te;
        if ($urandom_range(0, 3) == 0) cur_irq = cur_irq ^ 4'($urandom);
        applyStimulus(cur_irq, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 9) == 0), 4'($urandom),
                      {$urandom_range(0, 32'h3fff_ffff), 2'b00});
        #1;
        req = m_pend & m_mask;
        ti  = !m_trap && !kernel && !stall && (req != 4'h0);
        te  = !m_trap && !kernel && !stall && exc_in && !ti;
        checkOutput("rnd_take_irq", 64'(take_irq), 64'(ti));
        checkOutput("rnd_take_exc", 64'(take_exc), 64'(te));
        toEdge();
        low  = req & (~req + 4'd1);
        s    = hist[hist.size() - SYNC];
        d    = hist[hist.size() - SYNC - 1];
        rise = s & ~d;
        if (ti) begin
            m_epc   = pc_cur;
            m_cause = {1'b1, 4'(bitIndex(low))};
            m_trap  = 1'b1;
        end else if (te) begin
            m_epc   = pc_cur;
            m_cause = 5'h00;
            m_trap  = 1'b1;
        end else if (m_trap && eret) begin
            m_trap = 1'b0;
        end
        m_pend = (m_pend & ~(ti ? low : 4'h0)) | rise;
        if (mask_we) m_mask = mask_wdata;
        hist.push_back(irq_in);
        if (hist.size() > 8) void'(hist.pop_front());
        checkOutput("rnd_pending", 64'(pending), 64'(m_pend));
        checkOutput("rnd_mask", 64'(mask), 64'(m_mask));
        checkOutput("rnd_epc", 64'(epc), 64'(m_epc));
        checkOutput("rnd_cause", 64'(cause), 64'(m_cause));
        checkOutput("rnd_in_trap", 64'(in_trap), 64'(m_trap));
        toDrive();
    endtask

    initial begin
        logic [3:0] cur_irq;
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{4'h0, 0, 0, 0, 0, 1, 4'hF, 32'h0,        0, 0, 4'h0, 0, 5'h00, 32'h0};
        vecs[1]  = '{4'h4, 0, 0, 0, 0, 0, 4'h0, 32'h0,        0, 0, 4'h0, 0, 5'h00, 32'h0};
        vecs[2]  = '{4'h0, 0, 0, 0, 0, 0, 4'h0, 32'h0,        0, 0, 4'h0, 0, 5'h00, 32'h0};
        vecs[3]  = '{4'h0, 0, 0, 0, 0, 0, 4'h0, 32'h0,        0, 0, 4'h4, 0, 5'h00, 32'h0};
        vecs[4]  = '{4'h0, 0, 0, 0, 0, 0, 4'h0, 32'h00400010, 1, 0, 4'h0, 1, 5'h12, 32'h00400010};
        vecs[5]  = '{4'h0, 0, 0, 0, 0, 0, 4'h0, 32'h00400014, 0, 0, 4'h0, 1, 5'h12, 32'h00400010};
        vecs[6]  = '{4'h0, 0, 0, 0, 1, 0, 4'h0, 32'h80000180, 0, 0, 4'h0, 0, 5'h12, 32'h00400010};
        vecs[7]  = '{4'h0, 1, 0, 0, 0, 0, 4'h0, 32'h00400020, 0, 1, 4'h0, 1, 5'h00, 32'h00400020};
        vecs[8]  = '{4'h0, 1, 0, 0, 1, 0, 4'h0, 32'h00400024, 0, 0, 4'h0, 0, 5'h00, 32'h00400020};
        vecs[9]  = '{4'h0, 1, 1, 0, 0, 0, 4'h0, 32'h80000184, 0, 0, 4'h0, 0, 5'h00, 32'h00400020};
        vecs[10] = '{4'h0, 1, 0, 1, 0, 0, 4'h0, 32'h00400028, 0, 0, 4'h0, 0, 5'h00, 32'h00400020};

        rst_n = 1'b0;
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        toDrive();
        #1;
        checkOutput("reset_mask", 64'(mask), 64'h0);
        checkOutput("reset_pending", 64'(pending), 64'h0);
        checkOutput("reset_epc", 64'(epc), 64'h0);
        checkOutput("reset_cause", 64'(cause), 64'h0);
        checkOutput("reset_in_trap", 64'(in_trap), 64'h0);
        checkOutput("reset_take_irq", 64'(take_irq), 64'h0);
        rst_n = 1'b1;
        toDrive();

        // Directed vector table: single IRQ on line 2, then exception paths
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].irq, vecs[i].exc, vecs[i].kern, vecs[i].stl,
                          vecs[i].ert, vecs[i].mwe, vecs[i].mwd, vecs[i].pc);
            checkPre($sformatf("vec%0d", i), vecs[i].e_ti, vecs[i].e_te);
            toEdge();
            checkPost($sformatf("vec%0d", i), vecs[i].e_pend, vecs[i].e_trap);
            checkOutput($sformatf("vec%0d_cause", i), 64'(cause), 64'(vecs[i].e_cause));
            checkOutput($sformatf("vec%0d_epc", i), 64'(epc), 64'(vecs[i].e_epc));
            toDrive();
        end
        checkOutput("table_mask", 64'(mask), 64'hF);

        // Lines 1 and 3 together: line 1 first, line 3 after eret once kernel drops
        pc_cur = 32'h00400100;
        dirCycle("pri_c1", 4'hA, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        dirCycle("pri_c2", 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        dirCycle("pri_c3", 4'h0, 0, 0, 0, 0, 0, 0, 4'hA, 0);
        dirCycle("pri_c4", 4'h0, 0, 0, 0, 0, 1, 0, 4'h8, 1);
        checkOutput("pri_cause1", 64'(cause), 64'h11);
        checkOutput("pri_epc1", 64'(epc), 64'h00400100);
        dirCycle("pri_c5", 4'h0, 0, 1, 0, 1, 0, 0, 4'h8, 0);
        dirCycle("pri_c6", 4'h0, 0, 1, 0, 0, 0, 0, 4'h8, 0);
        pc_cur = 32'h00400104;
        dirCycle("pri_c7", 4'h0, 0, 0, 0, 0, 1, 0, 4'h0, 1);
        checkOutput("pri_cause3", 64'(cause), 64'h13);
        checkOutput("pri_epc3", 64'(epc), 64'h00400104);
        dirCycle("pri_c8", 4'h0, 0, 0, 0, 1, 0, 0, 4'h0, 0);

        // IRQ beats a simultaneous exception; the exception re-traps after eret
        pc_cur = 32'h00400200;
        dirCycle("ie_c1", 4'h1, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        dirCycle("ie_c2", 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        dirCycle("ie_c3", 4'h0, 0, 0, 0, 0, 0, 0, 4'h1, 0);
        dirCycle("ie_c4", 4'h0, 1, 0, 0, 0, 1, 0, 4'h0, 1);
        checkOutput("ie_cause_irq", 64'(cause), 64'h10);
        dirCycle("ie_c5", 4'h0, 1, 0, 0, 1, 0, 0, 4'h0, 0);
        dirCycle("ie_c6", 4'h0, 1, 0, 0, 0, 0, 1, 4'h0, 1);
        checkOutput("ie_cause_exc", 64'(cause), 64'h00);
        dirCycle("ie_c7", 4'h0, 0, 0, 0, 1, 0, 0, 4'h0, 0);

        // Masked line accumulates pending and fires the cycle after unmasking
        applyStimulus(4'h0, 0, 0, 0, 0, 1'b1, 4'h0, 32'h00400300);
        toEdge();
        checkOutput("msk_zero", 64'(mask), 64'h0);
        toDrive();
        dirCycle("msk_c1", 4'h1, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        dirCycle("msk_c2", 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        dirCycle("msk_c3", 4'h0, 0, 0, 0, 0, 0, 0, 4'h1, 0);
        applyStimulus(4'h0, 0, 0, 0, 0, 1'b1, 4'h1, 32'h00400300);
        checkPre("msk_wr", 0, 0);
        toEdge();
        checkOutput("msk_one", 64'(mask), 64'h1);
        checkPost("msk_wr", 4'h1, 0);
        toDrive();
        dirCycle("msk_c5", 4'h0, 0, 0, 0, 0, 1, 0, 4'h0, 1);
        dirCycle("msk_c6", 4'h0, 0, 0, 0, 1, 0, 0, 4'h0, 0);

        // Stall/kernel defer the take; new edges in TRAP only set pending
        dirCycle("stl_c1", 4'h1, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        dirCycle("stl_c2", 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        dirCycle("stl_c3", 4'h0, 0, 0, 0, 0, 0, 0, 4'h1, 0);
        for (int i = 0; i < 5; i++) begin
            dirCycle($sformatf("stl_hold%0d", i), 4'h0, 0, (i >= 3), (i < 3), 0,
                     0, 0, 4'h1, 0);
        end
        pc_cur = 32'h00400400;
        dirCycle("stl_rel", 4'h0, 0, 0, 0, 0, 1, 0, 4'h0, 1);
        checkOutput("stl_epc", 64'(epc), 64'h00400400);
        dirCycle("trp_c1", 4'h1, 0, 0, 0, 0, 0, 0, 4'h0, 1);
        dirCycle("trp_c2", 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 1);
        dirCycle("trp_c3", 4'h0, 0, 0, 0, 0, 0, 0, 4'h1, 1);
        dirCycle("trp_c4", 4'h0, 1, 0, 0, 0, 0, 0, 4'h1, 1);
        dirCycle("trp_eret", 4'h0, 0, 0, 0, 1, 0, 0, 4'h1, 0);
        pc_cur = 32'h00400500;
        dirCycle("trp_again", 4'h0, 0, 0, 0, 0, 1, 0, 4'h0, 1);
        checkOutput("trp_epc", 64'(epc), 64'h00400500);

        // Asynchronous reset in the middle of a trap
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_in_trap", 64'(in_trap), 64'h0);
        checkOutput("mid_rst_epc", 64'(epc), 64'h0);
        checkOutput("mid_rst_cause", 64'(cause), 64'h0);
        checkOutput("mid_rst_mask", 64'(mask), 64'h0);
        checkOutput("mid_rst_pending", 64'(pending), 64'h0);
        checkOutput("mid_rst_takes", 64'({take_irq, take_exc}), 64'h0);
        repeat (2) @(posedge clk);
        toDrive();
        rst_n = 1'b1;
        dirCycle("post_rst", 4'h0, 1'b0, 0, 0, 0, 0, 0, 4'h0, 0);
        checkOutput("post_rst_mask", 64'(mask), 64'h0);

        // Randomised phase against the behavioural model
        doReset();
        modelReset();
        cur_irq = 4'h0;
        for (int i = 0; i < 1500; i++) begin
            randomCycle(cur_irq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_exc_ctrl.md
Name: irq_exc_ctrl

Overview:
- Sequential interrupt/exception controller; parametrised successor to the single-IRQ combinational control decode.
- Latches N masked interrupt lines and the decoder's illegal-instruction flag, arbitrates them, and emits one-cycle trap pulses that drive PCSrc (IRQ vector / exception vector).
- Captures EPC and cause; tracks kernel residency until eret.
- Sits beside the main control unit in the single-cycle/pipelined datapath.

Parameters:
- NUM_IRQ, 4, number of interrupt lines (1..16)
- PC_WIDTH, 32, width of PC/EPC
- EDGE_MODE, 1, 1 = rising-edge latched pending, 0 = level-sensitive pending
- SYNC_STAGES, 2, synchroniser depth on irq_in (>=1)
- ID_W, 4, width of line-index field in cause (ceil(log2(NUM_IRQ)) <= ID_W)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- irq_in  in  NUM_IRQ  external interrupt requests, asynchronous
- exc_in  in  1  illegal-instruction flag from decode, valid this cycle
- pc_cur  in  PC_WIDTH  PC of instruction currently in decode
- kernel  in  1  PC[31] of current instruction; no traps taken while high
- stall  in  1  pipeline cannot redirect this cycle; suppresses take
- eret  in  1  return-from-trap (jr $k0 in kernel), one cycle
- mask_we  in  1  write strobe for mask register
- mask_wdata  in  NUM_IRQ  new mask value (1 = enabled)
- mask  out  NUM_IRQ  current mask
- pending  out  NUM_IRQ  current pending bits (pre-mask)
- take_irq  out  1  redirect to IRQ vector this cycle (PCSrc=100)
- take_exc  out  1  redirect to exception vector this cycle (PCSrc=101)
- epc  out  PC_WIDTH  saved return PC
- cause  out  ID_W+1  {is_irq, line_id}; is_irq=0 means exception, id=0
- in_trap  out  1  high from the cycle after take until the cycle after eret

Behaviour:
- Reset (rst_n low, async): sync stages 0, pending 0, mask all 0, epc 0, cause 0, state IDLE, in_trap 0; take_irq/take_exc 0.
- Synchroniser: irq_in passes SYNC_STAGES flops → irq_s. Edge detect compares irq_s with its one-cycle delayed copy.
- Pending, EDGE_MODE=1: bit sets on rising edge of irq_s; clears only when that line is taken. Set and clear in the same cycle on the same line: set wins, so a bit stays pending.
- Pending, EDGE_MODE=0: pending = irq_s; the source must drop its request itself.
- req = pending & mask. Winner = lowest-index set bit of req.
- take_irq (combinational) = state IDLE & ~kernel & ~stall & |req.
- take_exc (combinational) = state IDLE & ~kernel & ~stall & exc_in & ~take_irq. IRQ has priority over exception; the excepting instruction is refetched after return and re-traps.
- On a clock edge with take_irq or take_exc:
  - epc <= pc_cur
  - cause <= {1, winner} for an IRQ, {0, 0} for an exception
  - winner's pending bit clears (edge mode)
  - state <= TRAP; in_trap goes high the next cycle
- State TRAP: take_* held 0 regardless of inputs (no nesting). eret → IDLE; in_trap falls the next cycle. eret in IDLE is ignored.
- mask_we takes effect at the next edge. A take in the same cycle uses the old mask.
- Masked lines still accumulate pending; they fire once unmasked.
- stall high: no take and no state change. Pending keeps accumulating.
- kernel high in IDLE: traps are deferred, not dropped. exc_in is discarded while kernel=1.
- epc/cause hold their value until the next take.

Test Plan:
- Reset, mask=4'b1111, EDGE_MODE=1: pulse irq_in[2] → after SYNC_STAGES+1 cycles take_irq=1 for 1 cycle, epc=pc_cur (e.g. 0x00400010), cause=5'b1_0010, pending[2]→0, in_trap=1.
- irq_in[1] and irq_in[3] rise together → line 1 taken first (cause id=1). After eret → line 3 taken (id=3) on the first IDLE cycle with kernel=0.
- exc_in=1 with irq pending on line 0 → take_irq only, cause=5'b1_0000. After eret, exc_in still 1 → take_exc, cause=5'b0_0000.
- mask=0, pulse irq_in[0] → no take, pending[0]=1. Write mask=4'b0001 → take_irq the cycle after the write.
- stall=1 or kernel=1 for 5 cycles with req set → take suppressed. Release → take on the first free cycle with the correct epc. In TRAP, new edges set pending but take stays 0.
- Assert rst_n low mid-TRAP → all outputs 0 immediately. After release, state IDLE, mask 0.
